// File: rtl/des_key_scheduler.sv
// DES key schedule generator: streams the sixteen 48-bit round subkeys with a
// valid/ready handshake, in K1..K16 (encrypt) or K16..K1 (decrypt) order.
module des_key_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        abort,
    input  logic        subkey_ready,
    output logic        subkey_valid,
    output logic [47:0] subkey,
    output logic [3:0]  key_idx,
    output logic        last,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Permuted choice 1; FIPS key bit n sits at k[64-n], output bit 1 is the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        pc1 = {k[7],  k[15], k[23], k[31], k[39], k[47], k[55],
               k[63], k[6],  k[14], k[22], k[30], k[38], k[46],
               k[54], k[62], k[5],  k[13], k[21], k[29], k[37],
               k[45], k[53], k[61], k[4],  k[12], k[20], k[28],
               k[1],  k[9],  k[17], k[25], k[33], k[41], k[49],
               k[57], k[2],  k[10], k[18], k[26], k[34], k[42],
               k[50], k[58], k[3],  k[11], k[19], k[27], k[35],
               k[43], k[51], k[59], k[36], k[44], k[52], k[60]};
    endfunction

    // Permuted choice 2; CD bit n (FIPS numbering) sits at cd[56-n].
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        pc2 = {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
               cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
               cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
               cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
               cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
               cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
               cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
               cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
    endfunction

    // C and D rotate as independent 28-bit rings.
    function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (two) rotl_cd = {c[25:0], c[27:26], d[25:0], d[27:26]};
        else     rotl_cd = {c[26:0], c[27],    d[26:0], d[27]};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (two) rotr_cd = {c[1:0], c[27:2], d[1:0], d[27:2]};
        else     rotr_cd = {c[0],   c[27:1], d[0],   d[27:1]};
    endfunction

    // Shift schedule S[1..16]: rounds 1, 2, 9 and 16 rotate by one, the rest by two.
    function automatic logic shift_is_two(input logic [4:0] round_no);
        shift_is_two = !(round_no == 5'd1 || round_no == 5'd2 ||
                         round_no == 5'd9 || round_no == 5'd16);
    endfunction

    logic [0:0]  r_state;
    logic [55:0] r_cd;
    logic [3:0]  r_cnt;
    logic        r_dir;
    logic        r_done;

    logic [55:0] w_pc1;
    logic [55:0] w_cd_next;
    logic        w_run;
    logic        w_hs;
    logic [4:0]  w_enc_round;
    logic [4:0]  w_dec_round;

    assign w_pc1       = pc1(key_in);
    assign w_run       = (r_state == ST_RUN);
    assign w_hs        = w_run & subkey_ready;
    // Encrypt steps CD(r+1) -> CD(r+2); decrypt undoes the rotation of round 16-r.
    assign w_enc_round = {1'b0, r_cnt} + 5'd2;
    assign w_dec_round = 5'd16 - {1'b0, r_cnt};

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        w_cd_next = r_cd;
        if (r_dir) w_cd_next = rotr_cd(r_cd, shift_is_two(w_dec_round));
        else       w_cd_next = rotl_cd(r_cd, shift_is_two(w_enc_round));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cd    <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                    r_dir   <= decrypt;
                    // Decrypt starts at CD16, which equals CD0 after 28 total rotations.
                    r_cd    <= decrypt ? w_pc1 : rotl_cd(w_pc1, 1'b0);
                end
            end else begin
                if (abort) begin
                    r_state <= ST_IDLE;
                    r_cd    <= '0;
                    r_cnt   <= '0;
                end else if (w_hs) begin
                    if (r_cnt == 4'd15) begin
                        r_state <= ST_IDLE;
                        r_cd    <= '0;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cd  <= w_cd_next;
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
            end
        end
    end

    // Key material is gated to zero whenever no schedule is running.
    always_comb begin
        subkey_valid = 1'b0;
        subkey       = '0;
        key_idx      = '0;
        last         = 1'b0;
        if (w_run) begin
            subkey_valid = 1'b1;
            subkey       = pc2(r_cd);
            key_idx      = r_dir ? (4'd15 - r_cnt) : r_cnt;
            last         = (r_cnt == 4'd15);
        end
    end

    assign busy = w_run;
    assign done = r_done;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed bench for des_key_scheduler using the classic 133457799BBCDFF1 vector set.
module tb_des_key_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        abort;
    logic        subkey_ready;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  key_idx;
    logic        last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] K_TBL [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .abort        (abort),
        .subkey_ready (subkey_ready),
        .subkey_valid (subkey_valid),
        .subkey       (subkey),
        .key_idx      (key_idx),
        .last         (last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_key(input string tag, input logic [47:0] exp_key,
                             input logic [3:0] exp_idx, input logic exp_last);
        check({tag, "_valid"}, 64'(subkey_valid), 64'd1);
        check({tag, "_subkey"}, 64'(subkey), 64'(exp_key));
        check({tag, "_idx"}, 64'(key_idx), 64'(exp_idx));
        check({tag, "_last"}, 64'(last), 64'(exp_last));
        check({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_valid"}, 64'(subkey_valid), 64'd0);
        check({tag, "_subkey"}, 64'(subkey), 64'd0);
        check({tag, "_idx"}, 64'(key_idx), 64'd0);
        check({tag, "_last"}, 64'(last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'(exp_done));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        abort        = 1'b0;
        subkey_ready = 1'b0;
        #2;
        check_idle("reset", 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_reset", 1'b0);

        // Encrypt, ready held high; start pulses mid-run and at the final handshake are ignored.
        key_in       = KEY;
        decrypt      = 1'b0;
        start        = 1'b1;
        subkey_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_key("enc", K_TBL[i], 4'(i), i == 15);
            if (i == 5 || i == 15) begin
                start   = 1'b1;
                decrypt = 1'b1;
            end else begin
                start   = 1'b0;
                decrypt = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check_idle("enc_end", 1'b1);

        // Decrypt started in the done cycle.
        start   = 1'b1;
        decrypt = 1'b1;
        tick();
        start   = 1'b0;
        decrypt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_key("dec", K_TBL[15-i], 4'(15 - i), i == 15);
            tick();
        end
        check_idle("dec_end", 1'b1);
        tick();
        check_idle("dec_after", 1'b0);

        // Backpressure: ready low for three cycles at r=4.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_key("bp", K_TBL[i], 4'(i), i == 15);
            if (i == 4) begin
                subkey_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check_key("bp_stall", K_TBL[4], 4'd4, 1'b0);
                end
                subkey_ready = 1'b1;
            end
            tick();
        end
        check_idle("bp_end", 1'b1);

        // Abort at r=7 together with a handshake.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_key("ab_r7", K_TBL[7], 4'd7, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("ab_next", 1'b0);
        tick();
        check_idle("ab_nodone", 1'b0);

        // Abort while idle must not block a start.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_key("ab_restart", K_TBL[0], 4'd0, 1'b0);
        tick();
        check_key("ab_restart2", K_TBL[1], 4'd1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("ab_clean", 1'b0);

        // Asynchronous reset at r=10.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_key("rst_r10", K_TBL[10], 4'd10, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle("rst_async", 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_idle("rst_wait", 1'b0);

        // All-zero key gives sixteen zero subkeys; a start mid-run is ignored.
        key_in = '0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_key("zero", 48'h0, 4'(i), i == 15);
            start   = (i == 3);
            decrypt = (i == 3);
            tick();
        end
        start   = 1'b0;
        decrypt = 1'b0;
        check_idle("zero_end", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
